// File: rtl/seq_mem_pkg.sv
// Shared types and limits for the seq_mem_d1_pl family of sequential memories.
package seq_mem_pkg;

  typedef enum logic {MEM_CLEAR, MEM_IDLE} seq_mem_state_t;

  localparam int MAX_READ_LATENCY = 4;

endpackage

// File: rtl/seq_mem_rd_pipe.sv
// Valid/data delay line carrying read results; every stage holds its data until
// a new valid word arrives, so the last stage doubles as the held read output.
module seq_mem_rd_pipe
  import seq_mem_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             src_vld,
  input  logic [WIDTH-1:0] src_dat,
  output logic             dst_vld,
  output logic [WIDTH-1:0] dst_dat
);

  if (DEPTH < 1 || DEPTH > MAX_READ_LATENCY) begin : g_bad_depth
    $error("seq_mem_rd_pipe: DEPTH must be within 1..%0d", MAX_READ_LATENCY);
  end

  logic [DEPTH-1:0] vld_p;
  logic [WIDTH-1:0] dat_p [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= '0;
      for (int i = 0; i < DEPTH; i++) dat_p[i] <= '0;
    end else begin
      // stage p0: word sampled from the array at the accept edge
      vld_p[0] <= src_vld;
      if (src_vld) dat_p[0] <= src_dat;
      // stages p1..: pure delay, data only moves with its valid
      for (int i = 1; i < DEPTH; i++) begin
        vld_p[i] <= vld_p[i-1];
        if (vld_p[i-1]) dat_p[i] <= dat_p[i-1];
      end
    end
  end

  assign dst_vld = vld_p[DEPTH-1];
  assign dst_dat = dat_p[DEPTH-1];

endmodule

// File: rtl/seq_mem_d1_pl.sv
// 1-D sequential memory with configurable read latency, post-reset clear
// sequence (busy) and a sticky protocol/range error flag.
module seq_mem_d1_pl
  import seq_mem_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int SIZE           = 16,
  parameter int IDX_SIZE       = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [IDX_SIZE-1:0] addr0,
  input  logic                read_en,
  output logic [WIDTH-1:0]    out,
  output logic                read_done,
  input  logic [WIDTH-1:0]    in,
  input  logic                write_en,
  output logic                write_done,
  output logic                busy,
  output logic                error
);

  if (SIZE > 2**IDX_SIZE) begin : g_bad_size
    $error("seq_mem_d1_pl: SIZE %0d does not fit IDX_SIZE %0d", SIZE, IDX_SIZE);
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_bad_lat
    $error("seq_mem_d1_pl: READ_LATENCY %0d outside 1..%0d", READ_LATENCY, MAX_READ_LATENCY);
  end

  localparam seq_mem_state_t RST_STATE = (CLEAR_ON_RESET != 0) ? MEM_CLEAR : MEM_IDLE;
  localparam logic [IDX_SIZE:0]   SIZE_V   = (IDX_SIZE+1)'(SIZE);
  localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(SIZE - 1);

  logic [WIDTH-1:0]    mem [SIZE];
  seq_mem_state_t      state;
  seq_mem_state_t      state_nxt;
  logic [IDX_SIZE-1:0] clr_cnt;
  logic                clr_last;
  logic                idle;
  logic                in_range;
  logic                rd_acc;
  logic                wr_acc;
  logic                conflict;
  logic [WIDTH-1:0]    rd_dat;

  assign clr_last = (clr_cnt == LAST_IDX);
  assign idle     = (state == MEM_IDLE);
  assign in_range = ({1'b0, addr0} < SIZE_V);
  assign rd_acc   = idle & read_en & ~write_en;
  assign wr_acc   = idle & write_en & ~read_en;
  assign conflict = idle & read_en & write_en;
  // out-of-range reads still complete, carrying zero
  assign rd_dat   = in_range ? mem[addr0] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RST_STATE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      MEM_CLEAR: begin
        busy = 1'b1;
        if (clr_last) state_nxt = MEM_IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             clr_cnt <= '0;
    else if (state == MEM_CLEAR && !clr_last) clr_cnt <= clr_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!idle)                  mem[clr_cnt] <= '0;
    else if (wr_acc && in_range) mem[addr0]  <= in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_done <= 1'b0;
      error      <= 1'b0;
    end else begin
      write_done <= wr_acc;
      error      <= error | conflict | ((rd_acc | wr_acc) & ~in_range);
    end
  end

  seq_mem_rd_pipe #(
    .WIDTH (WIDTH),
    .DEPTH (READ_LATENCY)
  ) u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .src_vld (rd_acc),
    .src_dat (rd_dat),
    .dst_vld (read_done),
    .dst_dat (out)
  );

endmodule

// File: tb/tb_seq_mem_d1_pl.sv
// Bench for seq_mem_d1_pl: three instances (different SIZE / READ_LATENCY) share
// one stimulus stream and are checked every cycle against a completion-calendar model.
module tb_seq_mem_d1_pl;

  localparam int NI = 3;
  // element 0: SIZE 16 lat 3, element 1: SIZE 16 lat 2, element 2: SIZE 12 lat 4
  localparam logic [NI-1:0][7:0] SIZE_T = {8'd12, 8'd16, 8'd16};
  localparam logic [NI-1:0][7:0] LAT_T  = {8'd4,  8'd2,  8'd3};

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [3:0]  a;
    logic [31:0] d;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  addr0;
  logic        read_en;
  logic        write_en;
  logic [31:0] din;

  logic [31:0] out_w  [NI];
  logic        rdd_w  [NI];
  logic        wrd_w  [NI];
  logic        busy_w [NI];
  logic        err_w  [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    seq_mem_d1_pl #(
      .WIDTH          (32),
      .SIZE           (int'(SIZE_T[g])),
      .IDX_SIZE       (4),
      .READ_LATENCY   (int'(LAT_T[g])),
      .CLEAR_ON_RESET (1)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .addr0      (addr0),
      .read_en    (read_en),
      .out        (out_w[g]),
      .read_done  (rdd_w[g]),
      .in         (din),
      .write_en   (write_en),
      .write_done (wrd_w[g]),
      .busy       (busy_w[g]),
      .error      (err_w[g])
    );
  end

  // reference model state
  logic [31:0] m_mem [NI][16];
  logic [31:0] m_out [NI];
  logic        m_rd  [NI];
  logic        m_wd  [NI];
  logic        m_err [NI];
  int          m_clr [NI];
  logic        m_sv  [NI][8];
  logic [31:0] m_sd  [NI][8];
  int          edge_n;

  int vectors;
  int miscompares;

  function automatic logic [35:0] obs(input int k);
    return {rdd_w[k], out_w[k], wrd_w[k], busy_w[k], err_w[k]};
  endfunction

  function automatic logic [35:0] expv(input int k);
    return {m_rd[k], m_out[k], m_wd[k], (m_clr[k] > 0), m_err[k]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_out[k] = '0;
      m_rd[k]  = 1'b0;
      m_wd[k]  = 1'b0;
      m_err[k] = 1'b0;
      m_clr[k] = int'(SIZE_T[k]);
      for (int s = 0; s < 8; s++) m_sv[k][s] = 1'b0;
    end
  endtask

  // Applies one request for one clock edge and advances the model.
  task automatic step(input op_t op);
    read_en  = op.rd;
    write_en = op.wr;
    addr0    = op.a;
    din      = op.d;
    @(posedge clk);
    edge_n++;
    for (int k = 0; k < NI; k++) begin
      int sz;
      int slot;
      sz = int'(SIZE_T[k]);
      m_wd[k] = 1'b0;
      if (m_clr[k] > 0) begin
        m_mem[k][sz - m_clr[k]] = '0;
        m_clr[k]--;
      end else if (op.rd && op.wr) begin
        m_err[k] = 1'b1;
      end else if (op.wr) begin
        m_wd[k] = 1'b1;
        if (int'(op.a) < sz) m_mem[k][op.a] = op.d;
        else                 m_err[k] = 1'b1;
      end else if (op.rd) begin
        slot = (edge_n + int'(LAT_T[k]) - 1) % 8;
        m_sv[k][slot] = 1'b1;
        m_sd[k][slot] = (int'(op.a) < sz) ? m_mem[k][op.a] : 32'h0;
        if (int'(op.a) >= sz) m_err[k] = 1'b1;
      end
      slot = edge_n % 8;
      m_rd[k] = m_sv[k][slot];
      if (m_sv[k][slot]) m_out[k] = m_sd[k][slot];
      m_sv[k][slot] = 1'b0;
    end
    #1;
  endtask

  function automatic op_t mk(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] d);
    op_t o;
    o.rd = rd; o.wr = wr; o.a = a; o.d = d;
    return o;
  endfunction

  task automatic test_reset();
    op_t q[$];
    read_en = 1'b0; write_en = 1'b0; addr0 = '0; din = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (obs(k) !== expv(k)) begin
        miscompares++;
        $display("FAIL reset_values inst%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    reset = 1'b0;
    // requests during the clear window must be ignored
    for (int i = 0; i < 12; i++)
      q.push_back(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
    repeat (6) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd5, 32'h0));
    repeat (5) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL clear_then_read inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_write_read();
    op_t q[$];
    q.push_back(mk(1'b0, 1'b1, 4'd3, 32'hDEADBEEF));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd3, 32'h0));
    repeat (5) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL write_read inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t q[$];
    q.push_back(mk(1'b0, 1'b1, 4'd1, 32'h11));
    q.push_back(mk(1'b0, 1'b1, 4'd2, 32'h22));
    q.push_back(mk(1'b0, 1'b1, 4'd3, 32'h33));
    q.push_back(mk(1'b1, 1'b0, 4'd1, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd2, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd3, 32'h0));
    repeat (6) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL back_to_back inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_random_inrange();
    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 2);
      step(mk(r == 1, r == 2, 4'($urandom_range(0, 11)), $urandom));
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL random_inrange inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_conflict();
    op_t q[$];
    q.push_back(mk(1'b0, 1'b1, 4'd7, 32'hA5A5_0007));
    q.push_back(mk(1'b1, 1'b1, 4'd7, 32'h1234_5678));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd7, 32'h0));
    repeat (6) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL conflict inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    op_t q[$];
    q.push_back(mk(1'b0, 1'b1, 4'd13, 32'hAB));
    q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd13, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd11, 32'h0));
    repeat (6) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL out_of_range inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_random_full();
    for (int i = 0; i < 300; i++) begin
      step(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom));
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL random_full inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    op_t q[$];
    q.push_back(mk(1'b0, 1'b1, 4'd2, 32'hCAFE_0002));
    q.push_back(mk(1'b1, 1'b0, 4'd2, 32'h0));
    repeat (5) q.push_back(mk(1'b0, 1'b0, 4'd0, 32'h0));
    q.push_back(mk(1'b1, 1'b1, 4'd4, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd2, 32'h0));
    q.push_back(mk(1'b1, 1'b0, 4'd2, 32'h0));
    foreach (q[i]) begin
      step(q[i]);
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL inflight_setup inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
    read_en = 1'b0; write_en = 1'b0;
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < NI; k++) begin
      vectors++;
      if (obs(k) !== expv(k)) begin
        miscompares++;
        $display("FAIL async_reset inst%0d got %h want %h", k, obs(k), expv(k));
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(mk(1'b0, 1'b0, 4'd0, 32'h0));
      for (int k = 0; k < NI; k++) begin
        vectors++;
        if (obs(k) !== expv(k)) begin
          miscompares++;
          $display("FAIL after_reset inst%0d edge%0d got %h want %h", k, edge_n, obs(k), expv(k));
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    edge_n      = 0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_random_inrange();
    test_conflict();
    test_reset();
    test_out_of_range();
    test_random_full();
    test_reset_inflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
